// File: rtl/sr_ff_bank.sv
// Bank of WIDTH edge-triggered SR flip-flops with a global enable and selectable S=R=1 resolution.
// Conflicting requests are reported per bit, in a sticky error bit and in a saturating edge counter.
module sr_ff_bank #(
  parameter int                 WIDTH = 8,
  parameter int                 MODE  = 0,
  parameter logic [WIDTH-1:0]   INIT  = '0,
  parameter int                 CNT_W = 8
) (
  input  logic              C,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  S,
  input  logic [WIDTH-1:0]  R,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Qp,
  output logic [WIDTH-1:0]  conflict,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Out-of-range MODE values fall back to hold.
  localparam int MODE_EFF = (MODE >= 0 && MODE <= 3) ? MODE : 0;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] conflict_q, conflict_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] conf_val;
  logic             any_c;

  function automatic logic [WIDTH-1:0] resolve_conflict(input logic [WIDTH-1:0] cur);
    case (MODE_EFF)
      1:       resolve_conflict = '1;
      2:       resolve_conflict = '0;
      3:       resolve_conflict = ~cur;
      default: resolve_conflict = cur;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cur);
    sat_inc = (cur == '1) ? cur : cur + CNT_W'(1);
  endfunction

  always_comb begin
    both     = S & R;
    any_c    = en & (|both);
    conf_val = resolve_conflict(q_q);

    q_d = q_q;
    if (en)
      q_d = (q_q & ~S & ~R) | (S & ~R) | (both & conf_val);

    conflict_d = en ? both : '0;

    // A fresh conflict outranks a simultaneous clear.
    err_d = err_q;
    if (any_c)
      err_d = 1'b1;
    else if (err_clr)
      err_d = 1'b0;

    cnt_d = cnt_q;
    if (err_clr && any_c)
      cnt_d = CNT_W'(1);
    else if (err_clr)
      cnt_d = '0;
    else if (any_c)
      cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge C or posedge rst) begin
    if (rst) begin
      q_q        <= INIT;
      conflict_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Q            = q_q;
  assign Qp           = ~q_q;
  assign conflict     = conflict_q;
  assign err_sticky   = err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: four instances (one per MODE) plus a CNT_W=2 instance share stimulus.
module tb_sr_ff_bank;

  logic       C = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] S = '0;
  logic [7:0] R = '0;
  logic       err_clr = 1'b0;

  logic [7:0] q   [4];
  logic [7:0] qp  [4];
  logic [7:0] cf  [4];
  logic       err [4];
  logic [7:0] cnt [4];

  logic [7:0] s_q, s_qp, s_cf;
  logic       s_err;
  logic [1:0] s_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 C = ~C;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    sr_ff_bank #(.WIDTH(8), .MODE(m), .INIT(8'hA5), .CNT_W(8)) u_dut (
      .C(C), .rst(rst), .en(en), .S(S), .R(R), .err_clr(err_clr),
      .Q(q[m]), .Qp(qp[m]), .conflict(cf[m]), .err_sticky(err[m]), .conflict_cnt(cnt[m])
    );
  end

  sr_ff_bank #(.WIDTH(8), .MODE(0), .INIT(8'hA5), .CNT_W(2)) u_sat (
    .C(C), .rst(rst), .en(en), .S(S), .R(R), .err_clr(err_clr),
    .Q(s_q), .Qp(s_qp), .conflict(s_cf), .err_sticky(s_err), .conflict_cnt(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic drive(input logic e, input logic [7:0] s, input logic [7:0] r, input logic clr);
    en = e; S = s; R = r; err_clr = clr;
  endtask

  initial begin
    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i * 8'h3B), 8'(~(i * 8'h3B)), i[0]);
      tick();
    end
    drive(1'b1, 8'hFF, 8'hFF, 1'b0);
    tick();
    for (int m = 0; m < 4; m++) check($sformatf("rst_q_m%0d", m), q[m], 8'hA5);
    check("rst_qp", qp[0], 8'h5A);
    check("rst_conflict", cf[0], 8'h00);
    check("rst_err", err[0], 1'b0);
    check("rst_cnt", cnt[0], 8'd0);
    check("rst_sat_cnt", s_cnt, 2'd0);

    rst = 1'b0;
    drive(1'b1, 8'h0F, 8'h00, 1'b0);
    tick();
    check("first_set_q", q[0], 8'hAF);
    check("first_set_qp", qp[0], 8'h50);

    // Basic reset / set / hold
    drive(1'b1, 8'h00, 8'h01, 1'b0); tick();
    check("clr_bit0", q[1], 8'hAE);
    drive(1'b1, 8'h01, 8'h00, 1'b0); tick();
    check("set_bit0", q[2], 8'hAF);
    drive(1'b1, 8'h00, 8'h01, 1'b0); tick();
    check("clr_bit0_again", q[0], 8'hAE);
    drive(1'b0, 8'hFF, 8'h00, 1'b0); tick();
    check("en0_hold", q[0], 8'hAE);
    check("en0_qp", qp[0], 8'h51);
    check("en0_conflict", cf[0], 8'h00);

    // Conflict resolution per MODE from Q=0F
    drive(1'b1, 8'h0F, 8'hF0, 1'b0); tick();
    check("load_0f", q[3], 8'h0F);
    drive(1'b1, 8'hFF, 8'hFF, 1'b0); tick();
    check("mode0_q", q[0], 8'h0F);
    check("mode1_q", q[1], 8'hFF);
    check("mode2_q", q[2], 8'h00);
    check("mode3_q", q[3], 8'hF0);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("conf_m%0d", m), cf[m], 8'hFF);
      check($sformatf("err_m%0d", m), err[m], 1'b1);
      check($sformatf("cnt_m%0d", m), cnt[m], 8'd1);
    end
    check("mode3_qp", qp[3], 8'h0F);

    // Clear, then saturate the 2-bit counter
    drive(1'b1, 8'h00, 8'h00, 1'b1); tick();
    check("clr_cnt", s_cnt, 2'd0);
    check("clr_err", s_err, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 8'hFF, 8'hFF, 1'b0); tick();
      check($sformatf("sat_cnt_%0d", k), s_cnt, (k > 3) ? 2'd3 : 2'(k));
      check($sformatf("wide_cnt_%0d", k), cnt[0], 8'(k));
    end
    check("mode3_after5", q[3], 8'h0F);
    check("mode1_after5", q[1], 8'hFF);
    drive(1'b1, 8'h00, 8'h00, 1'b1); tick();
    check("sat_clr_cnt", s_cnt, 2'd0);
    check("sat_clr_err", s_err, 1'b0);
    check("sat_clr_conf", s_cf, 8'h00);

    // Clear coinciding with a conflict
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'h01, 8'h01, 1'b0); tick();
    end
    check("pre_sim_cnt", s_cnt, 2'd3);
    check("pre_sim_err", s_err, 1'b1);
    drive(1'b1, 8'h01, 8'h01, 1'b1); tick();
    check("sim_err", s_err, 1'b1);
    check("sim_cnt", s_cnt, 2'd1);
    check("sim_wide_cnt", cnt[0], 8'd1);
    check("sim_conf", s_cf, 8'h01);
    drive(1'b0, 8'hFF, 8'hFF, 1'b0); tick();
    check("en0_no_count", cnt[0], 8'd1);
    check("en0_no_conf", cf[0], 8'h00);

    // Async reset between edges
    drive(1'b1, 8'h3C, 8'hC3, 1'b0); tick();
    drive(1'b1, 8'h01, 8'h01, 1'b0); tick();
    check("pre_rst_q", q[0], 8'h3C);
    check("pre_rst_cnt", cnt[0], 8'd2);
    drive(1'b1, 8'hFF, 8'h00, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("arst_q", q[0], 8'hA5);
    check("arst_qp", qp[0], 8'h5A);
    check("arst_conf", cf[0], 8'h00);
    check("arst_err", err[0], 1'b0);
    check("arst_cnt", cnt[0], 8'd0);
    tick();
    check("arst_held_q", q[1], 8'hA5);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised, clocked bank of SR flip-flops. It succeeds the single gated SR latch with a WIDTH-bit edge-triggered register array with per-bit set/reset inputs and a global enable. The illegal S=R=1 condition resolves deterministically through a selectable MODE, and the bank tracks conflicts with a per-bit flag, a sticky error bit and a saturating counter. It sits wherever the design previously instantiated individual controlled latches, e.g. status/flag registers driven by independent set and clear events.

## Interface
- WIDTH, 8: number of flip-flops (1..32).
- MODE, 0: S=R=1 resolution. 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle (JK behaviour).
- INIT, 0: WIDTH-bit value loaded into Q on reset.
- CNT_W, 8: width of conflict counter (2..16).

Ports:
- C  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  control/enable; bank updates only when 1 at the clock edge.
- S  in  WIDTH  per-bit set request.
- R  in  WIDTH  per-bit reset request.
- err_clr  in  1  synchronous clear of err_sticky and conflict_cnt.
- Q  out  WIDTH  registered flip-flop state.
- Qp  out  WIDTH  ~Q, combinational from the Q register, never equal to Q.
- conflict  out  WIDTH  registered: bit i = en & S[i] & R[i] at the previous edge.
- err_sticky  out  1  set by any conflict, held until err_clr.
- conflict_cnt  out  CNT_W  count of edges with en=1 and at least one conflicting bit; saturating.

## Operation
- Reset (rst=1, asynchronous, overrides everything): Q=INIT, Qp=~INIT, conflict=0, err_sticky=0, conflict_cnt=0. Held while rst=1. First update occurs on the first rising C edge after rst deasserts.
- Per bit i on rising C with en=1:
  - S=0,R=0: hold.
  - S=1,R=0: Q[i]<=1.
  - S=0,R=1: Q[i]<=0.
  - S=1,R=1: the MODE action (hold / 1 / 0 / ~Q[i]).
- en=0: Q holds for all bits regardless of S/R. No conflicts are recorded. conflict<=0.
- Conflict detection: any_c = en & |(S&R). conflict<=en ? S&R : 0 each edge.
- err_sticky: if any_c then 1, else if err_clr then 0, else hold. A new conflict wins over a simultaneous err_clr.
- conflict_cnt:
  - err_clr & any_c -> 1.
  - err_clr alone -> 0.
  - any_c alone -> cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - Otherwise hold.
  - Counts edges, not bits: multiple conflicting bits in one cycle add 1.
- Bits are fully independent. A conflict on bit i does not affect any other bit.
- MODE is elaboration-time only. Illegal MODE values (>3) behave as 0.

## Timing
- Q, conflict, err_sticky and conflict_cnt have 1-cycle latency from the sampled inputs. Qp follows Q with zero cycles (combinational inverter only).
- Inputs are sampled at the rising C edge only. Glitches between edges have no effect, unlike the level-sensitive latch.
- rst asserted mid-operation clears state immediately without waiting for C. Inputs present during reset are discarded.
- No handshake. Every enabled edge is a committed update.

## Test plan
- Reset: rst=1 with INIT=8'hA5 and toggling S/R -> Q=8'hA5, Qp=8'h5A, conflict=0, err_sticky=0, cnt=0. Then release rst, S=8'h0F, R=0, en=1, one edge -> Q=8'hAF.
- Basic set/reset/hold: en=1, S=8'h01 -> Q[0]=1. R=8'h01 -> Q[0]=0. en=0 with S=8'hFF -> Q unchanged. Qp always equals ~Q.
- Conflict per MODE: from Q=8'h0F, apply S=R=8'hFF for one edge -> MODE0 Q=8'h0F, MODE1 8'hFF, MODE2 8'h00, MODE3 8'hF0. In all modes conflict=8'hFF, err_sticky=1 and cnt=1 on the next cycle.
- Counter saturation: CNT_W=2, 5 consecutive enabled conflict edges -> cnt sequence 1,2,3,3,3. Then err_clr with no conflict -> cnt=0, err_sticky=0.
- Simultaneous clear and conflict: err_sticky=1, cnt=3, err_clr=1 and S=R=8'h01, en=1 -> err_sticky=1, cnt=1.
- Async reset mid-run: assert rst between clock edges while cnt=2 and Q=8'h3C -> all outputs reach reset values before the next edge.
